ahb_slave_mem: RTL and testbench

AHB_SLAVE_MEM -- requirements
Module: ahb_slave_mem

---
 rtl/ahb_slave_mem.sv | 148 ++++++++++++++
 tb/tb_ahb_slave_mem.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_slave_mem.sv
// AHB-Lite slave backed by a word-organised memory. It adds a configurable
// number of wait states to each OKAY data phase and returns a two-cycle
// ERROR response for bad size, misaligned or out-of-region transfers.
module ahb_slave_mem #(
  parameter int unsigned MEM_WORDS   = 256,
  parameter int unsigned WAIT_STATES = 0,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        hclk,
  input  logic        hreset,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [2:0]  hburst,
  input  logic [31:0] hwdata,
  output logic        hready,
  output logic [1:0]  hresp,
  output logic [31:0] hrdata
);

  localparam int unsigned AW           = $clog2(MEM_WORDS);
  localparam logic [31:0] REGION_BYTES = 32'(MEM_WORDS * 4);
  localparam logic [2:0]  CNT_INIT     = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;
  localparam logic [1:0]  RESP_OKAY    = 2'b00;
  localparam logic [1:0]  RESP_ERROR   = 2'b01;

  typedef enum logic [1:0] {IDLE, WAIT, ERR1, ERR2} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [2:0]      r_cnt;
  logic [2:0]      w_cnt_nxt;
  logic            r_dp;          // an OKAY data phase completes in the current IDLE cycle
  logic            w_dp_nxt;
  logic [AW-1:0]   r_idx;
  logic            r_write;
  logic [1:0]      r_size;
  logic [1:0]      r_lane;
  logic [31:0]     r_mem [MEM_WORDS];

  logic [31:0]     w_offset;
  logic            w_in_range;
  logic            w_misalign;
  logic            w_err;
  logic            w_accept;
  logic            w_ready;
  logic            w_wr_commit;
  logic            w_rd_phase;
  logic [3:0]      w_lanes;
  logic            w_unused;

  // hburst and the BUSY/IDLE distinction carry no meaning for this slave.
  assign w_unused = ^{hburst, htrans[0]};

  // Address-phase decode and error classification.
  assign w_offset    = haddr - BASE_ADDR;
  assign w_in_range  = (haddr >= BASE_ADDR) && (w_offset < REGION_BYTES);
  assign w_misalign  = ((hsize == 3'b001) && haddr[0]) ||
                       ((hsize == 3'b010) && (haddr[1:0] != 2'b00));
  assign w_err       = (hsize > 3'b010) || w_misalign || !w_in_range;

  // hready is high only in IDLE (which includes the last data-phase cycle) and ERR2.
  assign w_ready  = (r_state == IDLE) || (r_state == ERR2);
  assign hready   = w_ready;
  assign hresp    = ((r_state == ERR1) || (r_state == ERR2)) ? RESP_ERROR : RESP_OKAY;
  assign w_accept = hsel && htrans[1] && w_ready;

  assign w_rd_phase  = (r_state == IDLE) && r_dp && !r_write;
  assign w_wr_commit = (r_state == IDLE) && r_dp && r_write && !hreset;
  assign hrdata      = w_rd_phase ? r_mem[r_idx] : 32'h0;

  // State register; reset discards any captured transfer.
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      r_state <= IDLE;
      r_cnt   <= 3'd0;
      r_dp    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_dp    <= w_dp_nxt;
    end
  end

  // Next-state logic; a new acceptance overrides the current phase's successor.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_dp_nxt    = 1'b0;
    case (r_state)
      IDLE: w_state_nxt = IDLE;
      WAIT: begin
        if (r_cnt == 3'd0) begin
          w_state_nxt = IDLE;
          w_dp_nxt    = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - 3'd1;
        end
      end
      ERR1: w_state_nxt = ERR2;
      ERR2: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
    if (w_accept) begin
      if (w_err) begin
        w_state_nxt = ERR1;
      end else if (WAIT_STATES > 0) begin
        w_state_nxt = WAIT;
        w_cnt_nxt   = CNT_INIT;
      end else begin
        w_state_nxt = IDLE;
        w_dp_nxt    = 1'b1;
      end
    end
  end

  // Capture the address-phase attributes of each accepted transfer.
  always_ff @(posedge hclk) begin
    if (w_accept) begin
      r_idx   <= w_offset[AW+1:2];
      r_write <= hwrite;
      r_size  <= hsize[1:0];
      r_lane  <= haddr[1:0];
    end
  end

  // Byte-lane enables for the captured write size and address.
  always_comb begin
    w_lanes = 4'b0000;
    case (r_size)
      2'b00:   w_lanes[r_lane] = 1'b1;
      2'b01:   w_lanes = r_lane[1] ? 4'b1100 : 4'b0011;
      default: w_lanes = 4'b1111;
    endcase
  end

  // Commit write data at the end of the final data-phase cycle; memory is never reset.
  always_ff @(posedge hclk) begin
    if (w_wr_commit) begin
      for (int b = 0; b < 4; b++) begin
        if (w_lanes[b]) r_mem[r_idx][8*b +: 8] <= hwdata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Bench for ahb_slave_mem: three instances with different wait-state and
// region settings, directed scenarios plus randomized transfers, checked
// cycle by cycle against a transaction-level model.
module tb_ahb_slave_mem;

  logic        hclk = 1'b0;
  logic        hreset;
  logic        hsel   [3];
  logic [31:0] haddr  [3];
  logic [1:0]  htrans [3];
  logic        hwrite [3];
  logic [2:0]  hsize  [3];
  logic [2:0]  hburst [3];
  logic [31:0] hwdata [3];
  logic        hready [3];
  logic [1:0]  hresp  [3];
  logic [31:0] hrdata [3];

  int checks   = 0;
  int failures = 0;

  ahb_slave_mem #(.MEM_WORDS(256), .WAIT_STATES(0), .BASE_ADDR(32'h0000_0000)) u_dut0 (
    .hclk(hclk), .hreset(hreset), .hsel(hsel[0]), .haddr(haddr[0]), .htrans(htrans[0]),
    .hwrite(hwrite[0]), .hsize(hsize[0]), .hburst(hburst[0]), .hwdata(hwdata[0]),
    .hready(hready[0]), .hresp(hresp[0]), .hrdata(hrdata[0]));

  ahb_slave_mem #(.MEM_WORDS(256), .WAIT_STATES(3), .BASE_ADDR(32'h0000_0000)) u_dut1 (
    .hclk(hclk), .hreset(hreset), .hsel(hsel[1]), .haddr(haddr[1]), .htrans(htrans[1]),
    .hwrite(hwrite[1]), .hsize(hsize[1]), .hburst(hburst[1]), .hwdata(hwdata[1]),
    .hready(hready[1]), .hresp(hresp[1]), .hrdata(hrdata[1]));

  ahb_slave_mem #(.MEM_WORDS(64), .WAIT_STATES(2), .BASE_ADDR(32'h0000_1000)) u_dut2 (
    .hclk(hclk), .hreset(hreset), .hsel(hsel[2]), .haddr(haddr[2]), .htrans(htrans[2]),
    .hwrite(hwrite[2]), .hsize(hsize[2]), .hburst(hburst[2]), .hwdata(hwdata[2]),
    .hready(hready[2]), .hresp(hresp[2]), .hrdata(hrdata[2]));

  always #5 hclk = ~hclk;

  function automatic int ws_of(int k);
    case (k) 0: return 0; 1: return 3; default: return 2; endcase
  endfunction
  function automatic int words_of(int k);
    return (k == 2) ? 64 : 256;
  endfunction
  function automatic logic [31:0] base_of(int k);
    return (k == 2) ? 32'h0000_1000 : 32'h0000_0000;
  endfunction

  // One expected output cycle of a data phase.
  typedef struct {
    bit       rdy;
    bit [1:0] resp;
    bit       fin_rd;
    bit       fin_wr;
    int       idx;
    int       off;
    int       nb;
  } cyc_t;

  cyc_t        mq [3][$];
  logic [31:0] mmem   [3][4096];
  bit   [3:0]  mknown [3][4096];

  logic [31:0] pend_wd [3];
  int          acc_n   [3];
  logic [31:0] last_rd [3];
  int          last_lo [3];
  int          lo_cnt  [3];
  logic [1:0]  last_resp [3];

  function automatic bit is_err(int k, logic [31:0] a, logic [2:0] sz);
    longint lo;
    longint hi;
    lo = longint'(base_of(k));
    hi = lo + longint'(words_of(k)) * 4;
    if (sz > 3'd2) return 1'b1;
    if (sz == 3'd1 && a[0]) return 1'b1;
    if (sz == 3'd2 && a[1:0] != 2'b00) return 1'b1;
    if (longint'(a) < lo || longint'(a) >= hi) return 1'b1;
    return 1'b0;
  endfunction

  // Transaction-level model: on each edge retire the current expected cycle
  // (committing a finished write) and queue the cycles of a newly accepted transfer.
  task automatic model_loop();
    cyc_t c;
    cyc_t cur;
    bit   have;
    bit   rdy;
    int   nb;
    forever begin
      @(posedge hclk or posedge hreset);
      for (int k = 0; k < 3; k++) begin
        if (hreset) begin
          mq[k].delete();
        end else begin
          have = 1'b0;
          rdy  = 1'b1;
          if (mq[k].size() > 0) begin
            cur  = mq[k].pop_front();
            have = 1'b1;
            rdy  = cur.rdy;
          end
          if (have && cur.fin_wr) begin
            for (int b = 0; b < 4; b++) begin
              if (b >= cur.off && b < cur.off + cur.nb) begin
                mmem[k][cur.idx][b*8 +: 8] = hwdata[k][b*8 +: 8];
                mknown[k][cur.idx][b] = 1'b1;
              end
            end
          end
          if (hsel[k] && htrans[k][1] && rdy) begin
            c.fin_rd = 1'b0; c.fin_wr = 1'b0; c.idx = 0; c.off = 0; c.nb = 0;
            if (is_err(k, haddr[k], hsize[k])) begin
              c.rdy = 1'b0; c.resp = 2'b01; mq[k].push_back(c);
              c.rdy = 1'b1; mq[k].push_back(c);
            end else begin
              c.rdy = 1'b0; c.resp = 2'b00;
              for (int i = 0; i < ws_of(k); i++) mq[k].push_back(c);
              nb      = 1 << hsize[k];
              c.rdy    = 1'b1;
              c.fin_rd = !hwrite[k];
              c.fin_wr = hwrite[k];
              c.idx    = int'((haddr[k] - base_of(k)) >> 2);
              c.nb     = nb;
              c.off    = int'(haddr[k][1:0]) & ~(nb - 1);
              mq[k].push_back(c);
            end
          end
        end
      end
    end
  endtask

  // Compare every instance's outputs against the model on each falling edge.
  task automatic monitor_loop();
    cyc_t        c;
    bit          e_rdy;
    bit   [1:0]  e_resp;
    logic [31:0] e_rd;
    logic [31:0] mask;
    bit          fin_rd;
    forever begin
      @(negedge hclk);
      for (int k = 0; k < 3; k++) begin
        e_rdy = 1'b1; e_resp = 2'b00; e_rd = 32'h0; mask = 32'hFFFF_FFFF; fin_rd = 1'b0;
        if (!hreset && mq[k].size() > 0) begin
          c      = mq[k][0];
          e_rdy  = c.rdy;
          e_resp = c.resp;
          if (c.fin_rd) begin
            fin_rd = 1'b1;
            e_rd   = mmem[k][c.idx];
            for (int b = 0; b < 4; b++) mask[b*8 +: 8] = {8{mknown[k][c.idx][b]}};
          end
        end
        checks++;
        if (hready[k] !== e_rdy || hresp[k] !== e_resp || (hrdata[k] & mask) !== (e_rd & mask)) begin
          failures++;
          $display("FAIL cycle dut%0d t=%0t: got hready=%0b hresp=%0d hrdata=%h, want hready=%0b hresp=%0d hrdata=%h (mask %h)",
                   k, $time, hready[k], hresp[k], hrdata[k], e_rdy, e_resp, e_rd, mask);
        end
        if (fin_rd) last_rd[k] = hrdata[k];
        if (hready[k] === 1'b0) begin
          lo_cnt[k]++;
        end else begin
          last_lo[k]   = lo_cnt[k];
          lo_cnt[k]    = 0;
          last_resp[k] = hresp[k];
        end
      end
    end
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Drive one address phase and hold it until the slave accepts it.
  task automatic issue(int k, logic [31:0] a, logic w, logic [2:0] sz, logic [31:0] wd, logic [1:0] tr);
    int   n;
    logic r;
    n = 0;
    hsel[k] = 1'b1; haddr[k] = a; hwrite[k] = w; hsize[k] = sz; htrans[k] = tr;
    hburst[k] = 3'($urandom); hwdata[k] = pend_wd[k];
    do begin
      @(negedge hclk);
      r = hready[k];
      @(posedge hclk);
      n++;
    end while (r !== 1'b1 && n < 64);
    #1;
    acc_n[k] = n;
    if (r !== 1'b1) begin
      checks++; failures++;
      $display("FAIL accept_timeout dut%0d: hready stayed %b, want 1", k, r);
    end
    pend_wd[k] = wd;
    hsel[k] = 1'b0; htrans[k] = 2'b00;
  endtask

  // One cycle that must not be accepted.
  task automatic nop(int k, logic sel, logic [1:0] tr);
    hsel[k] = sel; htrans[k] = tr; hwrite[k] = 1'($urandom);
    haddr[k] = base_of(k) + 32'($urandom_range(0, 15)) * 4;
    hsize[k] = 3'd2; hburst[k] = 3'($urandom); hwdata[k] = pend_wd[k];
    @(posedge hclk); #1;
    hsel[k] = 1'b0; htrans[k] = 2'b00;
  endtask

  // Idle until the model has no outstanding data-phase cycles.
  task automatic drain(int k);
    int n;
    n = 0;
    hsel[k] = 1'b0; htrans[k] = 2'b00; hwdata[k] = pend_wd[k];
    do begin
      @(posedge hclk); #1;
      n++;
    end while (mq[k].size() != 0 && n < 64);
    if (mq[k].size() != 0) begin
      checks++; failures++;
      $display("FAIL drain_timeout dut%0d: %0d cycles outstanding, want 0", k, mq[k].size());
    end
  endtask

  int          rnd_r;
  logic [31:0] rnd_a;
  logic [2:0]  rnd_sz;

  initial begin
    hreset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      hsel[k] = 1'b0; haddr[k] = 32'h0; htrans[k] = 2'b00; hwrite[k] = 1'b0;
      hsize[k] = 3'd2; hburst[k] = 3'd0; hwdata[k] = 32'h0; pend_wd[k] = 32'h0;
      acc_n[k] = 0; last_rd[k] = 32'h0; last_lo[k] = 0; lo_cnt[k] = 0; last_resp[k] = 2'b00;
    end
    fork
      model_loop();
      monitor_loop();
    join_none

    repeat (2) @(posedge hclk);
    @(negedge hclk);
    for (int k = 0; k < 3; k++) begin
      chk("rst_hready", {31'b0, hready[k]}, 32'h1);
      chk("rst_hresp", {30'b0, hresp[k]}, 32'h0);
      chk("rst_hrdata", hrdata[k], 32'h0);
    end
    @(posedge hclk); #1;
    hreset = 1'b0;

    // Zero-wait write then back-to-back read of the same word.
    issue(0, 32'h10, 1'b1, 3'd2, 32'hDEAD_BEEF, 2'b10);
    issue(0, 32'h10, 1'b0, 3'd2, 32'h0, 2'b10);
    chk("no_bubble_accept_cycles", acc_n[0], 32'd1);
    drain(0);
    chk("wr_rd_data", last_rd[0], 32'hDEAD_BEEF);
    chk("wr_rd_lo_cycles", last_lo[0], 32'd0);

    // Byte write into a cleared word.
    issue(0, 32'h10, 1'b1, 3'd2, 32'h0000_0000, 2'b10);
    issue(0, 32'h11, 1'b1, 3'd0, 32'hAAAA_AAAA, 2'b11);
    issue(0, 32'h10, 1'b0, 3'd2, 32'h0, 2'b10);
    drain(0);
    chk("byte_lane_data", last_rd[0], 32'h0000_AA00);

    // Misaligned word write: two-cycle ERROR, memory untouched.
    issue(0, 32'h12, 1'b1, 3'd2, 32'h1234_5678, 2'b10);
    drain(0);
    chk("misalign_lo_cycles", last_lo[0], 32'd1);
    chk("misalign_resp", {30'b0, last_resp[0]}, 32'h1);
    issue(0, 32'h10, 1'b0, 3'd2, 32'h0, 2'b10);
    drain(0);
    chk("misalign_mem_kept", last_rd[0], 32'h0000_AA00);

    // First address past the region.
    issue(0, 32'h400, 1'b0, 3'd2, 32'h0, 2'b10);
    drain(0);
    chk("range_lo_cycles", last_lo[0], 32'd1);
    chk("range_resp", {30'b0, last_resp[0]}, 32'h1);

    // Three wait states on a read.
    issue(1, 32'h20, 1'b1, 3'd2, 32'hCAFE_F00D, 2'b10);
    drain(1);
    issue(1, 32'h20, 1'b0, 3'd2, 32'h0, 2'b10);
    drain(1);
    chk("ws3_lo_cycles", last_lo[1], 32'd3);
    chk("ws3_resp", {30'b0, last_resp[1]}, 32'h0);
    chk("ws3_data", last_rd[1], 32'hCAFE_F00D);

    // Reset pulse during a write's wait states discards the write.
    issue(2, 32'h1040, 1'b1, 3'd2, 32'h1111_2222, 2'b10);
    drain(2);
    issue(2, 32'h1040, 1'b1, 3'd2, 32'h3333_4444, 2'b10);
    hwdata[2] = pend_wd[2];
    #1;
    hreset = 1'b1;
    @(negedge hclk);
    chk("rst_mid_wait_hready", {31'b0, hready[2]}, 32'h1);
    chk("rst_mid_wait_hresp", {30'b0, hresp[2]}, 32'h0);
    @(posedge hclk); #1;
    hreset = 1'b0;
    issue(2, 32'h1040, 1'b0, 3'd2, 32'h0, 2'b10);
    drain(2);
    chk("rst_write_dropped", last_rd[2], 32'h1111_2222);
    nop(2, 1'b1, 2'b01);
    @(negedge hclk);
    chk("busy_hready", {31'b0, hready[2]}, 32'h1);
    chk("busy_hresp", {30'b0, hresp[2]}, 32'h0);
    @(posedge hclk); #1;

    // Randomized traffic on every instance.
    for (int k = 0; k < 3; k++) begin
      for (int it = 0; it < 150; it++) begin
        rnd_r = $urandom_range(0, 99);
        if (rnd_r < 12) begin
          if ($urandom_range(0, 1) == 1) nop(k, 1'b0, 2'($urandom_range(0, 3)));
          else nop(k, 1'b1, 2'($urandom_range(0, 1)));
        end else begin
          rnd_a  = base_of(k) + 32'($urandom_range(0, 15)) * 4;
          rnd_sz = 3'($urandom_range(0, 2));
          if ($urandom_range(0, 3) == 0) rnd_a = rnd_a + 32'($urandom_range(0, 3));
          else if (rnd_sz == 3'd0) rnd_a = rnd_a + 32'($urandom_range(0, 3));
          else if (rnd_sz == 3'd1) rnd_a = rnd_a + 32'($urandom_range(0, 1)) * 2;
          if (rnd_r < 18) rnd_sz = 3'($urandom_range(3, 7));
          else if (rnd_r < 24) begin
            if ($urandom_range(0, 1) == 1)
              rnd_a = base_of(k) + 32'(words_of(k) * 4) + 32'($urandom_range(0, 7)) * 4;
            else
              rnd_a = base_of(k) - 32'd4;
          end
          issue(k, rnd_a, 1'($urandom), rnd_sz, $urandom, ($urandom_range(0, 1) == 1) ? 2'b11 : 2'b10);
          if ($urandom_range(0, 4) == 0) nop(k, 1'b0, 2'b00);
        end
      end
      drain(k);
    end

    repeat (2) @(posedge hclk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
